// File: rtl/core_host_pkg.sv
// Shared types and constants for the host-side core sequencer.
package core_host_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    UNLOAD = 3'd4,
    FLUSH  = 3'd5
  } host_state_t;

endpackage

// File: rtl/host_out_reg.sv
// One-entry valid/ready output register: load when free, hold while stalled,
// drop valid after the final handshake when nothing new is loaded.
module host_out_reg
  import core_host_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              free
);

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;

  assign free      = !out_valid_reg || out_ready;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= load_data;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/core_host_ctrl.sv
// Host sequencer: loads operand bytes into core data memory, pulses start,
// waits for done (with timeout) and streams the result bytes back out.
module core_host_ctrl
  import core_host_pkg::*;
#(
  parameter int AW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 4,
  parameter int RES_BASE  = 4,
  parameter int RES_LEN   = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              host_owns_mem,
  output logic              core_start,
  input  logic              core_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int RUN_W = ($clog2(TIMEOUT) > 10) ? $clog2(TIMEOUT) : 10;

  host_state_t      state_reg, state_next;
  logic [7:0]       idx_reg, idx_next;
  logic [7:0]       ridx_reg, ridx_next;
  logic [RUN_W-1:0] run_ctr_reg, run_ctr_next;
  logic             timeout_err_reg, timeout_err_next;
  logic             out_load;
  logic             out_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      ridx_reg        <= '0;
      run_ctr_reg     <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      ridx_reg        <= ridx_next;
      run_ctr_reg     <= run_ctr_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    ridx_next        = ridx_reg;
    run_ctr_next     = run_ctr_reg;
    timeout_err_next = timeout_err_reg;
    in_ready         = 1'b0;
    mem_we           = 1'b0;
    mem_re           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = in_data;
    out_load         = 1'b0;
    core_start       = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        mem_addr = AW'(LOAD_BASE);
        mem_we   = in_valid;
        if (in_valid) begin
          timeout_err_next = 1'b0;
          idx_next         = 8'd1;
          state_next       = (LOAD_LEN == 1) ? START : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_addr = AW'(LOAD_BASE) + AW'(idx_reg);
        mem_we   = in_valid;
        if (in_valid) begin
          idx_next = idx_reg + 8'd1;
          if (idx_reg == 8'(LOAD_LEN - 1)) state_next = START;
        end
      end
      START: begin
        core_start   = 1'b1;
        run_ctr_next = '0;
        state_next   = RUN;
      end
      RUN: begin
        // done in the first RUN cycle is left over from the previous run
        if (core_done && run_ctr_reg != '0) begin
          ridx_next  = '0;
          state_next = UNLOAD;
        end else if (run_ctr_reg == RUN_W'(TIMEOUT - 1)) begin
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end else begin
          run_ctr_next = run_ctr_reg + 1'b1;
        end
      end
      UNLOAD: begin
        mem_re   = 1'b1;
        mem_addr = AW'(RES_BASE) + AW'(ridx_reg);
        if (out_free) begin
          out_load  = 1'b1;
          ridx_next = ridx_reg + 8'd1;
          if (ridx_reg == 8'(RES_LEN - 1)) state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (out_valid && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  host_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_data (mem_rdata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .free      (out_free)
  );

  assign busy          = (state_reg != IDLE);
  assign host_owns_mem = (state_reg != RUN);
  assign timeout_err   = timeout_err_reg;

endmodule

// File: doc/core_host_ctrl.md
Name: core_host_ctrl

Overview:
Host-side sequencer that sits directly upstream and downstream of the 9-bit-ISA core top level. It streams operand bytes into the core's data memory and pulses the core's start line. It then waits for the core's done flag and streams the result bytes back out over a valid/ready port. It owns the data-memory port only while the core is not running; the top-level mux selects the port owner with `host_owns_mem`.

Parameters:
AW, 8, data-memory address width
LOAD_BASE, 0, first data-memory address written with input bytes
LOAD_LEN, 4, number of input bytes per run (1..255)
RES_BASE, 4, first data-memory address read for results
RES_LEN, 4, number of result bytes per run (1..255)
TIMEOUT, 1000, maximum RUN cycles before abort (width 10 bits minimum)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  controller accepts input byte
out_valid  out  1  result byte valid
out_data  out  8  result byte
out_ready  in  1  consumer accepts result byte
mem_we  out  1  data-memory write enable
mem_re  out  1  data-memory read enable
mem_addr  out  AW  data-memory address
mem_wdata  out  8  data-memory write data
mem_rdata  in  8  data-memory read data, asynchronous (valid in the same cycle as mem_addr/mem_re)
host_owns_mem  out  1  1 = controller drives the memory port, 0 = core drives it
core_start  out  1  start line to the core; the core restarts its PC on the falling edge
core_done  in  1  core halt flag
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - Counters = 0.
  - out_valid = 0, out_data = 0, core_start = 0, timeout_err = 0.
  - busy = 0, host_owns_mem = 1.
- States: IDLE, LOAD, START, RUN, UNLOAD, FLUSH.
- IDLE:
  - in_ready = 1.
  - An accepted byte (in_valid & in_ready) is written to LOAD_BASE and moves the FSM to LOAD with idx = 1.
  - The same accept clears timeout_err.
  - If LOAD_LEN == 1, the FSM goes straight to START.
- LOAD:
  - in_ready = 1.
  - mem_we = in_valid & in_ready, mem_addr = LOAD_BASE + idx (mod 2^AW), mem_wdata = in_data. All combinational; write takes effect at the clock edge.
  - idx increments per accept.
  - After the LOAD_LEN-th accept, go to START.
  - in_valid low simply stalls; there is no timeout in LOAD.
- START:
  - core_start = 1 for exactly 1 cycle, then go to RUN with core_start = 0. This falling edge restarts the core.
  - in_ready = 0 in all states from START onward.
- RUN:
  - host_owns_mem = 0, mem_we = mem_re = 0.
  - run_ctr counts from 0.
  - core_done is ignored in the first RUN cycle (stale flag from the previous run).
  - From the second cycle on, core_done = 1 moves to UNLOAD with ridx = 0.
  - If run_ctr reaches TIMEOUT-1 without done: set timeout_err = 1 and go to IDLE. No results are emitted.
  - If core_done and timeout fire in the same cycle, done wins.
- UNLOAD:
  - mem_re = 1, mem_addr = RES_BASE + ridx.
  - When out_valid == 0, or on a handshake (out_valid & out_ready): load out_data <= mem_rdata, set out_valid = 1, and increment ridx.
  - After the RES_LEN-th byte has been loaded, go to FLUSH.
  - out_data and out_valid hold stable while out_ready = 0.
- FLUSH:
  - Hold the last byte until its handshake, then out_valid = 0 and go to IDLE.
  - Exactly RES_LEN handshakes occur per run.
- Address arithmetic wraps modulo 2^AW.
- busy = (state != IDLE).
- host_owns_mem = (state != RUN).
- Reset mid-operation aborts immediately to the reset values. No partial output is emitted afterwards.

Decomposition:
- Package core_host_pkg:
  - state enum typedef host_state_t (IDLE, LOAD, START, RUN, UNLOAD, FLUSH).
  - Constant DATA_W = 8.
- One natural sub-module: host_out_reg, a one-entry valid/ready output register with load and hold. It is used by UNLOAD and FLUSH.
- Everything else (FSM, index counters, run counter, memory mux) lives in core_host_ctrl.

Test Plan:
- Load: send 0x11, 0x22, 0x33, 0x44 with in_valid constant → mem_we at addr 0, 1, 2, 3 with matching data. core_start high for exactly 1 cycle on the cycle after the 4th accept.
- Run and unload: memory model returns addr+0xA0. core_done asserted 10 cycles after the core_start falling edge → out stream 0xA4, 0xA5, 0xA6, 0xA7 (RES_BASE = 4). busy drops the cycle after the 4th handshake.
- Backpressure: out_ready low for 3 cycles after the first out_valid → out_data stays 0xA4. No extra memory read advances. Still exactly 4 bytes are delivered.
- Stale done / timeout (TIMEOUT = 20): core_done held high through START and the first RUN cycle only, then low → no unload. timeout_err = 1 after 20 RUN cycles, state returns to IDLE, out_valid never rises. The next accepted input byte clears timeout_err.
- Reset mid-RUN: assert reset asynchronously mid-RUN (between clock edges) → outputs return to reset values immediately (busy = 0, host_owns_mem = 1). A following full run behaves as in the load and unload scenarios.
